// File: rtl/if_pc_redirect_ctrl_pkg.sv
// Shared constants and types for the IF PC redirect controller.
package if_pc_redirect_ctrl_pkg;

  // PC-select mux input encodings
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;  // sequential PC+2
  localparam logic [1:0] PC_SEL_BR  = 2'b01;  // EX branch target
  localparam logic [1:0] PC_SEL_JLR = 2'b10;  // RR register target
  localparam logic [1:0] PC_SEL_JAL = 2'b11;  // ID JAL target

  // Redirect FSM: RUN follows the mux, PEND replays a held target
  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/pc_redirect_prio.sv
// Oldest-instruction-wins priority among the three redirect requests.
module pc_redirect_prio
  import if_pc_redirect_ctrl_pkg::*;
(
  input  logic       jal_id,
  input  logic       jlr_rr,
  input  logic       br_taken_ex,
  output logic [1:0] pc_sel,
  output logic       redir,
  output logic       flush_ifid,
  output logic       flush_idrr,
  output logic       flush_rrex
);

  // EX is oldest, then RR, then ID; each squashes every younger stage
  always_comb begin
    pc_sel     = PC_SEL_SEQ;
    flush_ifid = 1'b0;
    flush_idrr = 1'b0;
    flush_rrex = 1'b0;
    if (br_taken_ex) begin
      pc_sel     = PC_SEL_BR;
      flush_ifid = 1'b1;
      flush_idrr = 1'b1;
      flush_rrex = 1'b1;
    end else if (jlr_rr) begin
      pc_sel     = PC_SEL_JLR;
      flush_ifid = 1'b1;
      flush_idrr = 1'b1;
    end else if (jal_id) begin
      pc_sel     = PC_SEL_JAL;
      flush_ifid = 1'b1;
    end
    redir = br_taken_ex | jlr_rr | jal_id;
  end

endmodule

// File: rtl/if_pc_redirect_ctrl.sv
// IF-stage PC redirect controller: selects the PC source, drives PC write
// enable and stage flushes, and holds a redirect target while imem is busy.
module if_pc_redirect_ctrl
  import if_pc_redirect_ctrl_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ready,
  input  logic             stall_if,
  input  logic             jal_id,
  input  logic             jlr_rr,
  input  logic             br_taken_ex,
  input  logic [DW-1:0]    pc_mux_in,
  output logic [1:0]       pc_sel,
  output logic             pc_we,
  output logic             pc_override,
  output logic [DW-1:0]    pc_override_val,
  output logic             flush_ifid,
  output logic             flush_idrr,
  output logic             flush_rrex,
  output logic [CNT_W-1:0] redirect_cnt
);

  state_t           state_reg, state_next;
  logic [DW-1:0]    pend_pc_reg, pend_pc_next;
  logic [CNT_W-1:0] cnt_reg;

  logic [1:0] prio_sel;
  logic       redir;
  logic       prio_ifid, prio_idrr, prio_rrex;
  logic       we_raw, override_raw;

  pc_redirect_prio u_prio (
    .jal_id      (jal_id),
    .jlr_rr      (jlr_rr),
    .br_taken_ex (br_taken_ex),
    .pc_sel      (prio_sel),
    .redir       (redir),
    .flush_ifid  (prio_ifid),
    .flush_idrr  (prio_idrr),
    .flush_rrex  (prio_rrex)
  );

  // State and pending-target registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      pend_pc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pend_pc_reg <= pend_pc_next;
    end
  end

  // Next state, pending capture and raw PC write/override controls
  always_comb begin
    state_next   = state_reg;
    pend_pc_next = pend_pc_reg;
    we_raw       = 1'b0;
    override_raw = 1'b0;
    case (state_reg)
      RUN: begin
        if (redir) begin
          // a redirect must land even if the hazard unit asks for a stall
          we_raw = imem_ready;
          if (!imem_ready) begin
            pend_pc_next = pc_mux_in;
            state_next   = PEND;
          end
        end else begin
          we_raw = imem_ready & ~stall_if;
        end
      end
      PEND: begin
        we_raw = imem_ready;
        if (redir) begin
          // a newer request belongs to an older instruction: it replaces the held one
          if (imem_ready) begin
            state_next = RUN;
          end else begin
            override_raw = 1'b1;
            pend_pc_next = pc_mux_in;
          end
        end else begin
          override_raw = 1'b1;
          if (imem_ready) state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Saturating count of cycles carrying a redirect request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (redir && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Outputs are held quiet while reset is asserted
  always_comb begin
    pc_sel      = rst_n ? prio_sel : PC_SEL_SEQ;
    pc_we       = rst_n & we_raw;
    pc_override = rst_n & override_raw;
    flush_ifid  = rst_n & prio_ifid;
    flush_idrr  = rst_n & prio_idrr;
    flush_rrex  = rst_n & prio_rrex;
  end

  assign pc_override_val = pend_pc_reg;
  assign redirect_cnt    = cnt_reg;

endmodule

// File: tb/tb_if_pc_redirect_ctrl.sv
// Self-checking bench for if_pc_redirect_ctrl: per-cycle behavioural model
// comparison plus directed literal checks.
module tb_if_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, imem_ready, stall_if, jal_id, jlr_rr, br_taken_ex;
  logic [15:0] pc_mux_in;
  logic [1:0]  pc_sel;
  logic        pc_we, pc_override, flush_ifid, flush_idrr, flush_rrex;
  logic [15:0] pc_override_val, redirect_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_pc_redirect_ctrl #(.DW(16), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_ready      (imem_ready),
    .stall_if        (stall_if),
    .jal_id          (jal_id),
    .jlr_rr          (jlr_rr),
    .br_taken_ex     (br_taken_ex),
    .pc_mux_in       (pc_mux_in),
    .pc_sel          (pc_sel),
    .pc_we           (pc_we),
    .pc_override     (pc_override),
    .pc_override_val (pc_override_val),
    .flush_ifid      (flush_ifid),
    .flush_idrr      (flush_idrr),
    .flush_rrex      (flush_rrex),
    .redirect_cnt    (redirect_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // "waiting" = a redirect target is held because imem was busy when it arrived
  logic        m_waiting;
  logic [15:0] m_target;
  int          m_count;
  bit          m_valid = 0;
  wire         m_any = jal_id | jlr_rr | br_taken_ex;

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (!rst_n) begin
      m_waiting <= 1'b0;
      m_target  <= 16'h0;
      m_count   <= 0;
    end else begin
      if (m_any && !imem_ready) begin
        m_waiting <= 1'b1;
        m_target  <= pc_mux_in;
      end else if (imem_ready) begin
        m_waiting <= 1'b0;
      end
      if (m_any) m_count <= (m_count >= 65535) ? 65535 : m_count + 1;
    end
  end

  // Compare every cycle, mid-period, against the model
  always @(negedge clk) begin : cmp
    logic [1:0] e_sel;
    logic       e_we, e_ovr, e_f1, e_f2, e_f3;
    if (m_valid) begin
      e_sel = br_taken_ex ? 2'd1 : jlr_rr ? 2'd2 : jal_id ? 2'd3 : 2'd0;
      e_f1  = m_any;
      e_f2  = br_taken_ex | jlr_rr;
      e_f3  = br_taken_ex;
      // write when fetch can go and: holding a target, redirecting, or not stalled
      e_we  = imem_ready & (m_waiting | m_any | !stall_if);
      // replay the held target unless a fresh redirect can go straight through
      e_ovr = m_waiting & !(m_any & imem_ready);
      if (!rst_n) begin
        e_sel = 2'd0; e_we = 0; e_ovr = 0; e_f1 = 0; e_f2 = 0; e_f3 = 0;
      end
      check("m_pc_sel", pc_sel, e_sel);
      check("m_pc_we", pc_we, e_we);
      check("m_pc_override", pc_override, e_ovr);
      check("m_override_val", pc_override_val, m_target);
      check("m_flush_ifid", flush_ifid, e_f1);
      check("m_flush_idrr", flush_idrr, e_f2);
      check("m_flush_rrex", flush_rrex, e_f3);
      check("m_redirect_cnt", redirect_cnt, m_count[15:0]);
    end
  end

  // Apply one cycle of inputs just after a rising edge, return at the falling edge
  task automatic drive(input logic rn, input logic rdy, input logic stl,
                       input logic jal, input logic jlr, input logic br,
                       input logic [15:0] mux);
    @(posedge clk);
    #1;
    rst_n = rn; imem_ready = rdy; stall_if = stl;
    jal_id = jal; jlr_rr = jlr; br_taken_ex = br; pc_mux_in = mux;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; imem_ready = 1; stall_if = 0;
    jal_id = 0; jlr_rr = 0; br_taken_ex = 0; pc_mux_in = 16'h0;

    // reset
    drive(0, 1, 0, 0, 0, 0, 16'h0);
    drive(0, 1, 0, 0, 0, 0, 16'h0);
    check("rst_pc_sel", pc_sel, 2'b00);
    check("rst_pc_we", pc_we, 1'b0);
    check("rst_flushes", {flush_ifid, flush_idrr, flush_rrex}, 3'b000);
    check("rst_cnt", redirect_cnt, 16'h0);
    drive(1, 1, 0, 0, 0, 0, 16'h0);
    check("run_pc_we", pc_we, 1'b1);

    // priority
    drive(1, 1, 0, 1, 1, 1, 16'h0);
    check("all3_sel", pc_sel, 2'b01);
    check("all3_we", pc_we, 1'b1);
    check("all3_flush", {flush_ifid, flush_idrr, flush_rrex}, 3'b111);
    drive(1, 1, 0, 1, 1, 0, 16'h0);
    check("cnt_after_br", redirect_cnt, 16'd1);
    check("jal_jlr_sel", pc_sel, 2'b10);
    check("jal_jlr_flush", {flush_ifid, flush_idrr, flush_rrex}, 3'b110);

    // stall vs redirect
    drive(1, 1, 1, 1, 0, 0, 16'h0);
    check("stall_jal_we", pc_we, 1'b1);
    check("stall_jal_sel", pc_sel, 2'b11);
    check("stall_jal_flush", {flush_ifid, flush_idrr, flush_rrex}, 3'b100);
    drive(1, 1, 1, 0, 0, 0, 16'h0);
    check("stall_we", pc_we, 1'b0);
    check("cnt_3", redirect_cnt, 16'd3);

    // JLR while imem busy -> pending, released 3 cycles later
    drive(1, 0, 0, 0, 1, 0, 16'h1A2C);
    check("jlr_busy_we", pc_we, 1'b0);
    drive(1, 0, 0, 0, 0, 0, 16'h0);
    check("pend_ovr", pc_override, 1'b1);
    check("pend_val", pc_override_val, 16'h1A2C);
    check("pend_we", pc_we, 1'b0);
    drive(1, 0, 0, 0, 0, 0, 16'h0);
    drive(1, 0, 1, 0, 0, 0, 16'h0);
    check("pend_hold_ovr", pc_override, 1'b1);
    drive(1, 1, 1, 0, 0, 0, 16'h0);
    check("pend_release_we", pc_we, 1'b1);
    check("pend_release_ovr", pc_override, 1'b1);
    drive(1, 1, 0, 0, 0, 0, 16'h0);
    check("back_run_ovr", pc_override, 1'b0);
    check("back_run_we", pc_we, 1'b1);
    check("cnt_4", redirect_cnt, 16'd4);

    // superseding redirect in PEND
    drive(1, 0, 0, 0, 1, 0, 16'h1A2C);
    drive(1, 0, 0, 0, 0, 1, 16'h0040);
    check("sup_busy_flush", {flush_ifid, flush_idrr, flush_rrex}, 3'b111);
    check("sup_busy_we", pc_we, 1'b0);
    check("sup_busy_val", pc_override_val, 16'h1A2C);
    drive(1, 0, 0, 0, 0, 0, 16'h0);
    check("sup_new_val", pc_override_val, 16'h0040);
    check("sup_new_ovr", pc_override, 1'b1);
    drive(1, 1, 0, 0, 0, 1, 16'h0077);
    check("sup_rdy_ovr", pc_override, 1'b0);
    check("sup_rdy_we", pc_we, 1'b1);
    check("sup_rdy_sel", pc_sel, 2'b01);
    drive(1, 1, 0, 0, 0, 0, 16'h0);
    check("sup_run_ovr", pc_override, 1'b0);
    check("sup_run_val", pc_override_val, 16'h0040);
    check("cnt_7", redirect_cnt, 16'd7);

    // saturating counter: bring it to FFFE with a long JAL run
    for (int i = 0; i < 65528; i++) drive(1, 1, 0, 1, 0, 0, 16'h0);
    check("cnt_fffe", redirect_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 0, 0, 16'h0);
      check("cnt_sat", redirect_cnt, 16'hFFFF);
    end
    drive(1, 1, 0, 0, 0, 0, 16'h0);
    check("cnt_sat_hold", redirect_cnt, 16'hFFFF);

    // reset in the middle of PEND
    drive(1, 0, 0, 0, 1, 0, 16'h1234);
    drive(1, 0, 0, 0, 0, 0, 16'h0);
    check("pend2_val", pc_override_val, 16'h1234);
    drive(0, 0, 0, 0, 0, 1, 16'h0);
    check("rstp_ovr", pc_override, 1'b0);
    check("rstp_sel", pc_sel, 2'b00);
    check("rstp_flush", {flush_ifid, flush_idrr, flush_rrex}, 3'b000);
    drive(0, 0, 0, 0, 0, 0, 16'h0);
    check("rstp_val", pc_override_val, 16'h0);
    check("rstp_cnt", redirect_cnt, 16'h0);
    drive(1, 0, 0, 0, 0, 0, 16'h0);
    check("after_rst_ovr", pc_override, 1'b0);
    check("after_rst_val", pc_override_val, 16'h0);
    check("after_rst_we", pc_we, 1'b0);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
